// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, instruction-memory request/response
// channel, and the valid/ready decode channel.
//   master : the fetch queue (drives imem requests and the decode channel)
//   slave  : the surroundings (execute redirect, memory, decode stage)
interface inst_fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready,
               imem_resp_valid, imem_resp_data, dec_ready,
        output imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready,
               imem_resp_valid, imem_resp_data, dec_ready,
        input  imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: owns the PC, issues in-order word fetches, buffers
// returned instructions in a DEPTH-entry FIFO and hands {inst, pc} to decode.
// Redirects flush the FIFO and mark all in-flight responses for discard.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - inst_fetch_queue_if.master (redirect, imem req/resp, decode channel)
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_fetch_queue_if.master    bus
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t         fifo [DEPTH];
    logic [31:0]    pc;
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count, live, drop;

    logic [CW+1:0]  credits;
    logic           req_fire, pop, push;
    logic           resp_drop, resp_live;
    logic [31:0]    resp_pc;

    // Every FIFO slot is reserved at request time, so a response can always be
    // written without backpressure.
    assign credits   = {2'b00, count} + {2'b00, live} + {2'b00, drop};

    // Responses are consumed oldest-first: pending discards go before kept ones.
    assign resp_drop = bus.imem_resp_valid && (drop != '0);
    assign resp_live = bus.imem_resp_valid && (drop == '0) && (live != '0);
    assign push      = resp_live && !bus.redirect_valid;

    // Live requests were issued back-to-back since the last redirect/reset, so
    // the oldest one's PC is the current PC rewound by one word per live entry.
    assign resp_pc   = pc - (32'(live) << 2);

    always_comb begin
        bus.imem_req_valid = !rst && !bus.redirect_valid && (credits < (CW+2)'(DEPTH));
        bus.imem_req_addr  = pc;
        bus.dec_valid      = !rst && !bus.redirect_valid && (count != '0);
        bus.dec_inst       = NOP;
        bus.dec_pc         = 32'h0;
        if (bus.dec_valid) begin
            bus.dec_inst = fifo[rd_ptr].inst;
            bus.dec_pc   = fifo[rd_ptr].pc;
        end
    end

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign pop      = bus.dec_valid && bus.dec_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            live   <= '0;
            drop   <= '0;
        end else if (bus.redirect_valid) begin
            // A response landing this cycle retires its own request first;
            // whatever is still outstanding becomes garbage to discard.
            pc     <= {bus.redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            drop   <= (drop - CW'(resp_drop)) + (live - CW'(resp_live));
            live   <= '0;
        end else begin
            if (req_fire)
                pc <= pc + 32'd4;
            live   <= live + CW'(req_fire) - CW'(resp_live);
            drop   <= drop - CW'(resp_drop);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            fifo[wr_ptr] <= '{inst: bus.imem_resp_data, pc: resp_pc};
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
    localparam logic [31:0] KEY = 32'h5A5A_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_queue_if bus ();

    inst_fetch_queue #(.RESET_PC(32'h100), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;

    // Memory model: fixed latency shift register, data = addr ^ KEY.
    logic [7:0]  pv;
    logic [31:0] pa [8];
    assign bus.imem_resp_valid = pv[lat-1];
    assign bus.imem_resp_data  = pa[lat-1] ^ KEY;

    logic [31:0] issued [$];
    int          iss_cyc [$];
    logic [31:0] dpc [$];
    logic [31:0] dinst [$];
    int          dcyc [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[6:0], bus.imem_req_valid && bus.imem_req_ready};
            pa[0] <= bus.imem_req_addr;
            for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            issued.push_back(bus.imem_req_addr);
            iss_cyc.push_back(cyc);
        end
        if (bus.dec_valid && bus.dec_ready) begin
            dpc.push_back(bus.dec_pc);
            dinst.push_back(bus.dec_inst);
            dcyc.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        issued.delete(); iss_cyc.delete();
        dpc.delete(); dinst.delete(); dcyc.delete();
    endtask

    // Reset, then release at a negedge; the first request is sampled on the next posedge.
    task automatic do_reset(input int l, input logic drdy);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.dec_ready = drdy;
        lat = l;
        step(2);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic check_insts(input string name);
        int bad = 0;
        foreach (dpc[i]) if (dinst[i] !== (dpc[i] ^ KEY)) bad++;
        checks++;
        if (bad != 0 || dpc.size() == 0) begin
            errs++;
            $display("FAIL %s inst/pc pairing: bad=%0d of %0d required bad=0", name, bad, dpc.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.dec_ready = 1'b1;
        step(3);
        #1;
        checks++; if (bus.imem_req_valid !== 1'b0) begin errs++; $display("FAIL reset req_valid got=%b exp=0", bus.imem_req_valid); end
        checks++; if (bus.dec_valid !== 1'b0) begin errs++; $display("FAIL reset dec_valid got=%b exp=0", bus.dec_valid); end
        checks++; if (bus.dec_inst !== NOP) begin errs++; $display("FAIL reset dec_inst got=%h exp=%h", bus.dec_inst, NOP); end
        checks++; if (bus.dec_pc !== 32'h0) begin errs++; $display("FAIL reset dec_pc got=%h exp=0", bus.dec_pc); end
        checks++; if (bus.imem_req_addr !== 32'h100) begin errs++; $display("FAIL reset req_addr got=%h exp=00000100", bus.imem_req_addr); end
    endtask

    task automatic test_stream();
        do_reset(1, 1'b1);
        step(12);
        checks++;
        if (issued.size() < 8 || dpc.size() < 6) begin
            errs++; $display("FAIL stream counts issued=%0d decoded=%0d exp>=8,>=6", issued.size(), dpc.size());
        end else begin
            int bad = 0;
            for (int i = 0; i < 8; i++)
                if (issued[i] !== 32'h100 + 32'(4*i) || iss_cyc[i] != iss_cyc[0] + i) bad++;
            checks++; if (bad != 0) begin errs++; $display("FAIL stream issue seq bad=%0d exp=0", bad); end
            checks++; if (dcyc[0] != iss_cyc[0] + 2) begin errs++; $display("FAIL stream first dec latency got=%0d exp=2", dcyc[0] - iss_cyc[0]); end
            bad = 0;
            for (int i = 0; i < 6; i++)
                if (dpc[i] !== 32'h100 + 32'(4*i) || dcyc[i] != dcyc[0] + i) bad++;
            checks++; if (bad != 0) begin errs++; $display("FAIL stream decode seq bad=%0d exp=0", bad); end
        end
        check_insts("stream");
    endtask

    task automatic test_stall();
        do_reset(1, 1'b0);
        step(10);
        #1;
        checks++; if (issued.size() != 4) begin errs++; $display("FAIL stall issue count got=%0d exp=4", issued.size()); end
        checks++; if (bus.imem_req_valid !== 1'b0) begin errs++; $display("FAIL stall req_valid got=%b exp=0", bus.imem_req_valid); end
        checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h100) begin errs++; $display("FAIL stall head got v=%b pc=%h exp v=1 pc=00000100", bus.dec_valid, bus.dec_pc); end
        bus.dec_ready = 1'b1;
        step(10);
        checks++;
        if (dpc.size() < 6 || issued.size() < 5) begin
            errs++; $display("FAIL stall drain counts decoded=%0d issued=%0d", dpc.size(), issued.size());
        end else begin
            int bad = 0;
            for (int i = 0; i < 6; i++) if (dpc[i] !== 32'h100 + 32'(4*i)) bad++;
            checks++; if (bad != 0) begin errs++; $display("FAIL stall drain order bad=%0d exp=0", bad); end
            checks++; if (issued[4] !== 32'h110) begin errs++; $display("FAIL stall resume addr got=%h exp=00000110", issued[4]); end
        end
        check_insts("stall");
    endtask

    task automatic test_redirect_inflight();
        do_reset(3, 1'b1);
        step(2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h2002;
        #1;
        checks++; if (bus.imem_req_valid !== 1'b0) begin errs++; $display("FAIL redir_inflight req_valid got=%b exp=0", bus.imem_req_valid); end
        step(1);
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.imem_req_addr !== 32'h2000) begin errs++; $display("FAIL redir_inflight next addr got=%h exp=00002000", bus.imem_req_addr); end
        step(12);
        checks++;
        if (issued.size() < 3 || dpc.size() < 2) begin
            errs++; $display("FAIL redir_inflight counts issued=%0d decoded=%0d", issued.size(), dpc.size());
        end else begin
            checks++; if (issued[0] !== 32'h100 || issued[1] !== 32'h104 || issued[2] !== 32'h2000) begin errs++; $display("FAIL redir_inflight issue seq got=%h,%h,%h exp=100,104,2000", issued[0], issued[1], issued[2]); end
            checks++; if (dpc[0] !== 32'h2000 || dpc[1] !== 32'h2004) begin errs++; $display("FAIL redir_inflight decode got=%h,%h exp=2000,2004", dpc[0], dpc[1]); end
        end
        check_insts("redir_inflight");
    endtask

    task automatic test_redirect_busy();
        // Two entries queued, two in flight, one response landing on the redirect cycle.
        do_reset(3, 1'b0);
        step(5);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h3000;
        bus.dec_ready = 1'b1;
        #1;
        checks++; if (bus.dec_valid !== 1'b0 || bus.dec_inst !== NOP || bus.dec_pc !== 32'h0) begin errs++; $display("FAIL redir_busy same-cycle got v=%b inst=%h pc=%h exp 0,00000013,0", bus.dec_valid, bus.dec_inst, bus.dec_pc); end
        step(1);
        bus.redirect_valid = 1'b0;
        bus.dec_ready = 1'b0;
        #1;
        checks++; if (bus.dec_valid !== 1'b0) begin errs++; $display("FAIL redir_busy flushed got=%b exp=0", bus.dec_valid); end
        checks++; if (dpc.size() != 0) begin errs++; $display("FAIL redir_busy popped old got=%0d exp=0", dpc.size()); end
        step(15);
        #1;
        // Full credit reappears only once every discard has been retired.
        checks++; if (issued.size() != 8) begin errs++; $display("FAIL redir_busy credit issued=%0d exp=8", issued.size()); end
        checks++; if (bus.dec_pc !== 32'h3000) begin errs++; $display("FAIL redir_busy head got=%h exp=00003000", bus.dec_pc); end
        bus.dec_ready = 1'b1;
        step(4);
        checks++;
        if (dpc.size() < 4) begin
            errs++; $display("FAIL redir_busy drain count got=%0d exp>=4", dpc.size());
        end else begin
            int bad = 0;
            for (int i = 0; i < 4; i++) if (dpc[i] !== 32'h3000 + 32'(4*i)) bad++;
            checks++; if (bad != 0) begin errs++; $display("FAIL redir_busy drain order bad=%0d exp=0", bad); end
        end
        check_insts("redir_busy");
    endtask

    task automatic test_ready_toggle();
        do_reset(1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            bus.imem_req_ready = (i % 2 == 0);
            if (i == 1) begin
                #1;
                checks++; if (bus.imem_req_addr !== 32'h104) begin errs++; $display("FAIL toggle held addr got=%h exp=00000104", bus.imem_req_addr); end
            end
            step(1);
        end
        bus.imem_req_ready = 1'b1;
        step(8);
        checks++;
        if (issued.size() < 6 || dpc.size() < 6) begin
            errs++; $display("FAIL toggle counts issued=%0d decoded=%0d", issued.size(), dpc.size());
        end else begin
            int bad = 0;
            for (int i = 0; i < 6; i++) if (issued[i] !== 32'h100 + 32'(4*i) || dpc[i] !== 32'h100 + 32'(4*i)) bad++;
            checks++; if (bad != 0) begin errs++; $display("FAIL toggle seq bad=%0d exp=0", bad); end
            checks++; if (iss_cyc[1] != iss_cyc[0] + 2) begin errs++; $display("FAIL toggle spacing got=%0d exp=2", iss_cyc[1] - iss_cyc[0]); end
        end
        check_insts("toggle");
    endtask

    task automatic test_wrap();
        do_reset(1, 1'b1);
        step(4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFE;
        #1;
        checks++; if (bus.dec_valid !== 1'b0 || bus.dec_inst !== NOP || bus.dec_pc !== 32'h0) begin errs++; $display("FAIL wrap idle outputs got v=%b inst=%h pc=%h exp 0,00000013,0", bus.dec_valid, bus.dec_inst, bus.dec_pc); end
        step(1);
        bus.redirect_valid = 1'b0;
        clear_logs();
        step(8);
        checks++;
        if (issued.size() < 2 || dpc.size() < 2) begin
            errs++; $display("FAIL wrap counts issued=%0d decoded=%0d", issued.size(), dpc.size());
        end else begin
            checks++; if (issued[0] !== 32'hFFFF_FFFC || issued[1] !== 32'h0) begin errs++; $display("FAIL wrap addr got=%h,%h exp=fffffffc,00000000", issued[0], issued[1]); end
            checks++; if (dpc[0] !== 32'hFFFF_FFFC || dpc[1] !== 32'h0) begin errs++; $display("FAIL wrap decode got=%h,%h exp=fffffffc,00000000", dpc[0], dpc[1]); end
        end
        check_insts("wrap");
    endtask

    task automatic test_reset_mid();
        do_reset(3, 1'b1);
        step(4);
        rst = 1'b1;
        #1;
        checks++; if (bus.dec_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin errs++; $display("FAIL rst_mid outputs got dv=%b rv=%b exp 0,0", bus.dec_valid, bus.imem_req_valid); end
        step(1);
        rst = 1'b0;
        clear_logs();
        step(10);
        checks++; if (dpc.size() == 0 || dpc[0] !== 32'h100) begin errs++; $display("FAIL rst_mid first decode got n=%0d pc=%h exp pc=00000100", dpc.size(), (dpc.size() != 0) ? dpc[0] : 32'hx); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_busy();
        test_ready_toggle();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
